aes256_byte_collector: RTL



---
 rtl/aes256_pkg.sv | 16 +
 rtl/aes256_timeout_cnt.sv | 37 +++
 rtl/aes256_byte_collector.sv | 128 ++++++++++++
 3 files changed

// File: rtl/aes256_pkg.sv
// Shared constants and state encoding for the AES-256 byte-serial blocks.
package aes256_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BYTE_W      = 8;
    localparam int BLOCK_W     = 128;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_COLLECT = 3'd3,
        ST_FULL    = 3'd4
    } collector_state_t;

endpackage

// File: rtl/aes256_timeout_cnt.sv
// Idle-cycle counter: counts enabled cycles, flags the cycle that would reach LIMIT.
module aes256_timeout_cnt #(
    parameter int LIMIT = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Expiry is reported on the enabled cycle that takes the count to LIMIT.
    assign expired_o = en_i && (cnt_q == W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes256_byte_collector.sv
// Requests a block from the byte serializer, gathers 16 bytes MSB-first and
// offers the 128-bit result on a valid/ready handshake.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | waiting for enable
//   ST_REQ     | one-cycle request pulse, counters cleared
//   ST_WAIT    | waiting for the first byte
//   ST_COLLECT | gathering bytes 1..15
//   ST_FULL    | block presented until the consumer takes it
module aes256_byte_collector
    import aes256_pkg::*;
#(
    parameter int TIMEOUT_CLOCKS = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pi_enable,
    output logic               po_next_val_req,
    input  logic               pi_next_val_ready,
    input  logic [BYTE_W-1:0]  pi_data,
    output logic               po_block_valid,
    input  logic               pi_block_ready,
    output logic [BLOCK_W-1:0] po_block,
    output logic               po_busy,
    output logic               po_error
);

    collector_state_t   state_q, state_d;
    logic [3:0]         count_q, count_d;
    logic [BLOCK_W-1:0] block_q, block_d;
    logic               req_q, req_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;

    logic active;
    logic timeout;
    logic tmo_en;
    logic tmo_clr;

    assign active  = (state_q == ST_WAIT) || (state_q == ST_COLLECT);
    assign tmo_en  = active && !pi_next_val_ready;
    assign tmo_clr = !active || pi_next_val_ready || timeout;

    aes256_timeout_cnt #(
        .LIMIT (TIMEOUT_CLOCKS)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (timeout)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        block_d = block_q;
        error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pi_enable) state_d = ST_REQ;
            end
            ST_REQ: begin
                count_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (pi_next_val_ready) begin
                    block_d = {block_q[BLOCK_W-BYTE_W-1:0], pi_data};
                    count_d = 4'd1;
                    state_d = ST_COLLECT;
                end else if (timeout) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                // Shifting MSB-first leaves byte k at [127-8k -: 8] once all 16 are in.
                if (pi_next_val_ready) begin
                    block_d = {block_q[BLOCK_W-BYTE_W-1:0], pi_data};
                    count_d = count_q + 4'd1;
                    if (count_q == 4'(BLOCK_BYTES - 1)) state_d = ST_FULL;
                end else if (timeout) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (pi_next_val_ready) error_d = 1'b1;
                if (valid_q && pi_block_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        req_d   = (state_d == ST_REQ);
        valid_d = (state_d == ST_FULL);
        busy_d  = (state_d == ST_REQ) || (state_d == ST_WAIT) || (state_d == ST_COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            block_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            block_q <= block_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            error_q <= error_d;
        end
    end

    assign po_next_val_req = req_q;
    assign po_block_valid  = valid_q;
    assign po_block        = block_q;
    assign po_busy         = busy_q;
    assign po_error        = error_q;

endmodule
